// File: rtl/svt_pack_pkg.sv
// Shared types for the nibble packer.
//   nib_t      : 4-bit nibble
//   byte_t     : 8-bit packed byte
//   pk_state_t : packer occupancy state
//   pack_nib() : joins two nibbles into a byte, choosing which nibble goes low
package svt_pack_pkg;

  typedef logic [3:0] nib_t;
  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } pk_state_t;

  // first_low=1: first nibble lands in bits [3:0]; otherwise in bits [7:4].
  function automatic byte_t pack_nib(input nib_t first, input nib_t second,
                                     input logic first_low);
    if (first_low) return (byte_t'(second) << 4) | byte_t'(first);
    else           return (byte_t'(first) << 4)  | byte_t'(second);
  endfunction

endpackage

// File: rtl/svt_nibble_packer.sv
// Packs a valid/ready stream of 4-bit nibbles into a registered valid/ready
// stream of bytes. in_last closes the current byte early, filling the missing
// second half with PAD_NIBBLE.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     nibble handshake
//   in_nib, in_last       nibble data and early-close flag
//   out_valid/out_ready   byte handshake
//   out_byte, out_pad     packed byte, 1 when its second half is padding
//   out_cnt               bytes consumed downstream, wrapping
module svt_nibble_packer #(
  parameter bit         NIB_FIRST_LOW = 1'b1,
  parameter logic [3:0] PAD_NIBBLE    = 4'h0,
  parameter int         CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_nib,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_pad,
  output logic [CNT_W-1:0] out_cnt
);

  import svt_pack_pkg::*;

  // Local nibble type deliberately shadows the package one.
  typedef logic [3:0] nib_t;

  pk_state_t        state_q;
  nib_t             held_q;
  byte_t            byte_q;
  logic             pad_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic pop;

  // Ready depends only on occupancy and downstream ready, never on in_valid.
  assign in_ready  = (state_q != S_FULL) || out_ready;
  assign out_valid = (state_q == S_FULL);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_byte = byte_q;
  assign out_pad  = pad_q;
  assign out_cnt  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      held_q  <= 4'h0;
      byte_q  <= 8'h00;
      pad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (pop) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        S_HALF: begin
          // in_last is irrelevant here: the byte closes either way.
          if (accept) begin
            byte_q  <= pack_nib(held_q, in_nib, NIB_FIRST_LOW);
            pad_q   <= 1'b0;
            state_q <= S_FULL;
          end
        end
        S_EMPTY, S_FULL: begin
          // A popping S_FULL behaves as S_EMPTY for the incoming nibble,
          // so streaming never loses a cycle.
          if ((state_q == S_EMPTY) || pop) begin
            if (accept && in_last) begin
              byte_q  <= pack_nib(in_nib, PAD_NIBBLE, NIB_FIRST_LOW);
              pad_q   <= 1'b1;
              state_q <= S_FULL;
            end else if (accept) begin
              held_q  <= in_nib;
              state_q <= S_HALF;
            end else begin
              state_q <= S_EMPTY;
            end
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_svt_nibble_packer.sv
module tb_svt_nibble_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, out_ready;
  logic [3:0] in_nib;

  logic        rdy0, rdy1, vld0, vld1, pad0, pad1;
  logic [7:0]  byte0, byte1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  svt_nibble_packer dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_nib(in_nib), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
    .out_byte(byte0), .out_pad(pad0), .out_cnt(cnt0)
  );

  svt_nibble_packer #(.NIB_FIRST_LOW(1'b0), .PAD_NIBBLE(4'h9), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_nib(in_nib), .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
    .out_byte(byte1), .out_pad(pad1), .out_cnt(cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bytes waiting downstream, plus the open half byte.
  typedef struct { logic [3:0] a; logic [3:0] b; bit pad; } ent_t;
  ent_t       q[$];
  bit         pend;
  logic [3:0] first;
  int         pops;
  logic [7:0] last0, last1;
  bit         lpad;

  task automatic model_reset();
    q.delete();
    pend  = 0;
    first = 4'h0;
    pops  = 0;
    last0 = 8'h00;
    last1 = 8'h00;
    lpad  = 0;
  endtask

  task automatic push_byte(input logic [3:0] a, input logic [3:0] b, input bit pad);
    ent_t e;
    e.a = a; e.b = b; e.pad = pad;
    q.push_back(e);
    // dut0: first nibble low, pad 0; dut1: first nibble high, pad 9.
    last0 = pad ? 8'(a) : 8'(a) + 8'(b) * 8'd16;
    last1 = pad ? 8'(a) * 8'd16 + 8'h9 : 8'(a) * 8'd16 + 8'(b);
    lpad  = pad;
  endtask

  task automatic check_outputs();
    check_val("out_valid0", vld0, q.size() > 0);
    check_val("out_valid1", vld1, q.size() > 0);
    check_val("out_byte0", byte0, last0);
    check_val("out_byte1", byte1, last1);
    check_val("out_pad0", pad0, lpad);
    check_val("out_pad1", pad1, lpad);
    check_val("out_cnt0", cnt0, pops % 65536);
    check_val("out_cnt1", cnt1, pops % 4);
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic cyc(input bit v, input logic [3:0] n, input bit l, input bit r);
    bit exp_rdy, acc, pop;
    in_valid = v; in_nib = n; in_last = l; out_ready = r;
    #1;
    exp_rdy = (q.size() == 0) || r;
    check_val("in_ready0", rdy0, exp_rdy);
    check_val("in_ready1", rdy1, exp_rdy);
    acc = v && exp_rdy;
    pop = (q.size() > 0) && r;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (acc) begin
      if (!pend && l) push_byte(n, 4'h0, 1'b1);
      else if (!pend) begin first = n; pend = 1; end
      else begin push_byte(first, n, 1'b0); pend = 0; end
    end
    check_outputs();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_valid0", vld0, 1'b0);
    check_val("rst_valid1", vld1, 1'b0);
    check_val("rst_cnt0", cnt0, 16'd0);
    check_val("rst_cnt1", cnt1, 2'd0);
    check_val("rst_byte0", byte0, 8'h00);
    check_val("rst_pad0", pad0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_nib = 4'h0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    #3;
    check_val("init_ready", rdy0, 1'b1);
    check_val("init_valid", vld0, 1'b0);
    check_val("init_byte", byte0, 8'h00);
    check_val("init_cnt", cnt0, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 4'h0, 0, 0);

    // Pairing
    cyc(1, 4'hA, 0, 1);
    cyc(1, 4'h5, 0, 0);
    check_val("pair_lo", byte0, 8'h5A);
    check_val("pair_hi", byte1, 8'hA5);
    check_val("pair_pad", pad0, 1'b0);
    cyc(0, 4'h0, 0, 1);

    // Pad on a lone nibble, then in_last on a second nibble is ignored
    cyc(1, 4'hC, 1, 0);
    check_val("pad_lo", byte0, 8'h0C);
    check_val("pad_hi", byte1, 8'hC9);
    check_val("pad_flag", pad0, 1'b1);
    cyc(1, 4'h1, 0, 1);
    cyc(1, 4'h2, 1, 0);
    check_val("last2_byte", byte0, 8'h21);
    check_val("last2_pad", pad0, 1'b0);

    // Backpressure: byte held, input stalled, then drained
    for (int i = 0; i < 5; i++) begin
      cyc(1, 4'h7, 0, 0);
      check_val("bp_ready", rdy0, 1'b0);
      check_val("bp_byte", byte0, 8'h21);
    end
    cyc(1, 4'h7, 0, 1);
    cyc(1, 4'h8, 0, 0);
    check_val("bp_after", byte0, 8'h87);
    cyc(0, 4'h0, 0, 1);

    // Streaming from a clean counter
    async_reset();
    for (int i = 0; i < 8; i++) cyc(1, 4'(i + 1), 0, 1);
    cyc(0, 4'h0, 0, 1);
    check_val("stream_cnt", cnt0, 16'd4);
    check_val("wrap_cnt4", cnt1, 2'd0);
    cyc(1, 4'hE, 0, 1);
    cyc(1, 4'hF, 0, 1);
    cyc(0, 4'h0, 0, 1);
    check_val("wrap_cnt5", cnt1, 2'd1);
    check_val("cnt5_wide", cnt0, 16'd5);

    // Reset while half a byte is held: held nibble is discarded
    cyc(1, 4'h6, 0, 1);
    async_reset();
    cyc(1, 4'h3, 0, 1);
    cyc(1, 4'h4, 0, 0);
    check_val("rst_half_byte", byte0, 8'h43);

    // Reset while a byte is waiting
    async_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, 4'($urandom), ($urandom % 5) == 0, ($urandom % 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
